// File: rtl/digit_sub_pkg.sv
// digit_sub_pkg: shared state encoding and sizing helpers for the digit-serial subtractor
package digit_sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(input int nd);
    return $clog2(nd) + 1;
  endfunction
endpackage

// File: rtl/digit_sub_cell.sv
// digit_sub_cell: DIGIT-bit subtract with borrow in/out
module digit_sub_cell #(
  parameter int DIGIT = 16
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] diff,
  output logic             bout
);
  // the extra top bit of the widened difference is the borrow-out
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - (DIGIT+1)'(bin);
endmodule

// File: rtl/digit_serial_subtractor.sv
// digit_serial_subtractor: recovers a1 = c - a2 mod 2^WIDTH, DIGIT bits per cycle
module digit_serial_subtractor
  import digit_sub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DIGIT = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_c_node,
  input  logic [WIDTH-1:0] io_a2_node,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_a1_node,
  output logic             io_borrow
);
  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(ND);
  if (WIDTH % DIGIT != 0) begin : g_chk
    $error("WIDTH must be a multiple of DIGIT");
  end
  state_t state, state_nxt;
  logic [WIDTH-1:0] c_q, a2_q;
  logic [CW-1:0] cnt;
  logic brw, bout, last;
  logic [DIGIT-1:0] diff;
  digit_sub_cell #(.DIGIT(DIGIT)) u_cell (
    .a   (c_q[DIGIT-1:0]),
    .b   (a2_q[DIGIT-1:0]),
    .bin (brw),
    .diff(diff),
    .bout(bout)
  );
  assign last = cnt == CW'(ND - 1);
  assign io_in_ready = state == IDLE;
  assign io_out_valid = state == DONE;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE && io_in_valid) ? BUSY :
                (state == BUSY && last) ? DONE :
                (state == DONE && io_out_ready) ? IDLE : state;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // result digits enter at the top so the first (least significant) digit ends at bit 0
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      c_q <= '0;
      a2_q <= '0;
      cnt <= '0;
      brw <= 1'b0;
      io_a1_node <= '0;
      io_borrow <= 1'b0;
    end else if (state == IDLE && io_in_valid) begin
      c_q <= io_c_node;
      a2_q <= io_a2_node;
      cnt <= '0;
      brw <= 1'b0;
    end else if (state == BUSY) begin
      c_q <= c_q >> DIGIT;
      a2_q <= a2_q >> DIGIT;
      io_a1_node <= (io_a1_node >> DIGIT) | (WIDTH'(diff) << (WIDTH - DIGIT));
      brw <= bout;
      cnt <= cnt + CW'(1);
      if (last) io_borrow <= bout;
    end
endmodule

// File: tb/tb_digit_serial_subtractor.sv
// tb_digit_serial_subtractor: scoreboard bench with directed vectors and adder round trip
module tb_digit_serial_subtractor;
  typedef struct packed {logic [63:0] a1; logic b;} exp_t;
  logic clock = 1'b0, reset = 1'b0;
  logic io_in_valid = 1'b0, io_out_ready = 1'b1;
  logic io_in_ready, io_out_valid, io_borrow;
  logic [63:0] io_c_node = '0, io_a2_node = '0, io_a1_node;
  int tests = 0, fails = 0;
  exp_t exp_q[$];
  digit_serial_subtractor #(.WIDTH(64), .DIGIT(16)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_c_node(io_c_node), .io_a2_node(io_a2_node),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_a1_node(io_a1_node), .io_borrow(io_borrow)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  always @(negedge clock)
    if (reset && io_out_valid && io_out_ready) begin
      exp_t e, g;
      tests++;
      g = '{io_a1_node, io_borrow};
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got a1=%h borrow=%b want none", io_a1_node, io_borrow);
      end else begin
        e = exp_q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL result: got a1=%h borrow=%b want a1=%h borrow=%b", g.a1, g.b, e.a1, e.b);
        end
      end
    end
  task automatic send(input logic [63:0] c, input logic [63:0] a2, input logic [63:0] ea, input logic eb);
    logic acc;
    acc = 1'b0;
    io_c_node = c;
    io_a2_node = a2;
    io_in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = io_in_ready;
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    if (acc) exp_q.push_back('{ea, eb});
    else chk("accept_timeout", 64'(acc), 64'd1);
  endtask
  task automatic drain();
    int i;
    for (i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask
  initial begin
    logic [63:0] a1, a2;
    logic [64:0] s;
    logic [63:0] corner [3];
    corner[0] = 64'd0;
    corner[1] = 64'd1;
    corner[2] = '1;
    #2;
    chk("rst_in_ready", 64'(io_in_ready), 64'd1);
    chk("rst_out_valid", 64'(io_out_valid), 64'd0);
    chk("rst_a1", io_a1_node, 64'd0);
    chk("rst_borrow", 64'(io_borrow), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send(64'h5, 64'h3, 64'h2, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    chk("lat_not_early", 64'(io_out_valid), 64'd0);
    @(posedge clock); #1;
    chk("lat_cycle4", 64'(io_out_valid), 64'd1);
    drain();
    send(64'h0001_0000_0000_0000, 64'h1, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
    drain();
    send(64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();
    io_out_ready = 1'b0;
    send(64'h100, 64'h1, 64'hFF, 1'b0);
    for (int i = 0; i < 20 && !io_out_valid; i++) begin @(posedge clock); #1; end
    io_in_valid = 1'b1;
    io_c_node = 64'h20;
    io_a2_node = 64'h5;
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 64'(io_out_valid), 64'd1);
      chk("bp_in_ready", 64'(io_in_ready), 64'd0);
      chk("bp_a1_stable", io_a1_node, 64'hFF);
      @(posedge clock); #1;
    end
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_idle_ready", 64'(io_in_ready), 64'd1);
    chk("bp_idle_valid", 64'(io_out_valid), 64'd0);
    @(posedge clock); #1;
    exp_q.push_back('{64'h1B, 1'b0});
    io_in_valid = 1'b0;
    chk("bp_new_taken", 64'(io_in_ready), 64'd0);
    drain();
    send(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 64'h9999_9999_9999_9999, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("mid_partial_nonzero", 64'(io_a1_node != 0), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(io_out_valid), 64'd0);
    chk("arst_a1", io_a1_node, 64'd0);
    chk("arst_borrow", 64'(io_borrow), 64'd0);
    chk("arst_in_ready", 64'(io_in_ready), 64'd1);
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    send(64'h10, 64'h4, 64'hC, 1'b0);
    drain();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = {1'b0, corner[i]} + {1'b0, corner[j]};
        send(s[63:0], corner[j], corner[i], s[64]);
        drain();
      end
    for (int k = 0; k < 1000; k++) begin
      a1 = {$urandom, $urandom};
      a2 = {$urandom, $urandom};
      s = {1'b0, a1} + {1'b0, a2};
      send(s[63:0], a2, a1, s[64]);
      drain();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
